nbit_serial_addsub: RTL and testbench
=====================================

NBIT_SERIAL_ADDSUB -- requirements
Module: nbit_serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 Parameter DIGIT, default 4: bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT, and N = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-007 a  input  WIDTH  operand A; sampled with start.
REQ-008 b  input  WIDTH  operand B; sampled with start.
REQ-009 s  output  WIDTH  result (sum or difference, modulo 2^WIDTH).
REQ-010 cout  output  1  carry out of bit WIDTH-1; for subtract, 1 = no borrow.
REQ-011 ovf  output  1  two's-complement signed overflow.
REQ-012 zero  output  1  high when s is all zeros.
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  single-cycle pulse marking completion.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-016 In IDLE with start=1 at a rising edge, the block SHALL latch a, b XOR {WIDTH{sub}}, and carry-in = sub, enter RUN, and set busy=1 and digit counter=0.
REQ-017 Each RUN cycle SHALL add one DIGIT-bit slice (LSB slice first) plus the running carry, write the slice into s, and store the slice carry-out.
REQ-018 After the Nth RUN cycle, the block SHALL return to IDLE, clear busy, and assert done for exactly one cycle; s, cout, ovf, and zero SHALL be valid in that same cycle.
REQ-019 Latency: start is accepted at edge E0 and done is high in the cycle following edge E0+N; busy is high for exactly N cycles.
REQ-020 cout SHALL equal the carry out of bit WIDTH-1 of the full-width sum a + (b XOR {sub}) + sub.
REQ-021 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-022 zero SHALL be registered together with the final slice and reflect the complete result.
REQ-023 s, cout, ovf, and zero SHALL hold their values from done until the next accepted start. During RUN, s is not guaranteed to be valid.
REQ-024 start asserted while busy=1 SHALL be ignored and not queued; a, b, and sub changes during RUN SHALL NOT affect the result.
REQ-025 start=1 in the same cycle as done SHALL be accepted, allowing back-to-back operations with no idle gap.
REQ-026 With DIGIT = WIDTH, the block SHALL complete in 1 RUN cycle (N=1) under the same handshake rules.
REQ-027 Digit counter width SHALL be ceil(log2(N+1)) minimum; the counter SHALL NOT wrap within an operation.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE and clear s, cout, ovf, busy, done, and all internal registers to 0, with zero=1.
REQ-029 Reset asserted mid-RUN SHALL abort the operation: no done pulse and no partial result retained.
REQ-030 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8, DIGIT=4, N=2 unless stated)
REQ-031 add 0x03 + 0x02 -> s=0x05, cout=0, ovf=0, zero=0, with done exactly 2 cycles after start is accepted.
REQ-032 add 0xFE + 0x02 -> s=0x00, cout=1, ovf=0, zero=1; add 0x7F + 0x01 -> s=0x80, cout=0, ovf=1.
REQ-033 sub 0x0C - 0x05 -> s=0x07, cout=1, ovf=0; sub 0x03 - 0x05 -> s=0xFE, cout=0, ovf=0; sub 0x80 - 0x01 -> s=0x7F, ovf=1.
REQ-034 start pulsed while busy with different operands -> ignored; first result unchanged; exactly one done. Back-to-back start on the done cycle -> second done 2 cycles later.
REQ-035 rst_n low in the first RUN cycle -> outputs cleared asynchronously, zero=1, no done pulse. The next operation 0x11 + 0x22 -> s=0x33.
REQ-036 With DIGIT=1, add 0xFF + 0x01 -> s=0x00, cout=1, and busy high for 8 cycles. With DIGIT=8, the same operation gives done 1 cycle after start.

Source files
------------

// File: rtl/nbit_serial_addsub.sv
// nbit_serial_addsub: digit-serial adder/subtractor, DIGIT bits per clock, LSB slice first
module nbit_serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, done_q, done_d;
  logic [DIGIT:0]   sum;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    sum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        a_d     = a;
        b_d     = b ^ {WIDTH{sub}};
        carry_d = sub;
        cnt_d   = '0;
      end
    end else begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      s_d     = WIDTH'({sum[DIGIT-1:0], s_q} >> DIGIT);
      carry_d = sum[DIGIT];
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
        cout_d  = sum[DIGIT];
        ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum[DIGIT-1] ^ sum[DIGIT];
        zero_d  = s_d == '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign busy = state_q == RUN;
  assign done = done_q;
endmodule

// File: tb/tb_nbit_serial_addsub.sv
// tb_nbit_serial_addsub: three instances (DIGIT 4, 1, 8) against an arithmetic reference model
module tb_nbit_serial_addsub;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [7:0] s_w[3];
  logic       cout_w[3], ovf_w[3], zero_w[3], busy_w[3], done_w[3];
  int         n_chk = 0, n_pass = 0;
  int         lat[3], nb[3], nd[3];
  int         m_rem[3];
  logic [7:0] m_s[3], p_s[3];
  logic       m_cout[3], m_ovf[3], m_zero[3], m_done[3], m_valid[3];
  logic       p_cout[3], p_ovf[3], p_zero[3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    nbit_serial_addsub #(.WIDTH(8), .DIGIT(g == 0 ? 4 : (g == 1 ? 1 : 8))) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
      .s(s_w[g]), .cout(cout_w[g]), .ovf(ovf_w[g]), .zero(zero_w[g]),
      .busy(busy_w[g]), .done(done_w[g])
    );
  end
  always #5 clk = ~clk;
  function automatic int nof(input int i);
    return i == 0 ? 2 : (i == 1 ? 8 : 1);
  endfunction
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] got %0h expected %0h", nm, i, act, exp);
  endtask
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_rem[i] = 0; m_s[i] = '0; m_cout[i] = 0; m_ovf[i] = 0; m_zero[i] = 1; m_done[i] = 0; m_valid[i] = 1;
      end else begin
        m_done[i] = 0;
        if (m_rem[i] > 0) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_done[i] = 1; m_valid[i] = 1;
            m_s[i] = p_s[i]; m_cout[i] = p_cout[i]; m_ovf[i] = p_ovf[i]; m_zero[i] = p_zero[i];
          end
        end else if (start) begin
          int sr;
          sr = sub ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
          p_s[i]    = 8'(sr);
          p_ovf[i]  = sr > 127 || sr < -128;
          p_cout[i] = sub ? (a >= b) : (int'(a) + int'(b) > 255);
          p_zero[i] = 8'(sr) == 8'h00;
          m_rem[i]   = nof(i);
          m_valid[i] = 0;
        end
      end
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("busy", i, busy_w[i], m_rem[i] > 0);
      chk("done", i, done_w[i], m_done[i]);
      if (m_valid[i]) begin
        chk("s", i, s_w[i], m_s[i]);
        chk("cout", i, cout_w[i], m_cout[i]);
        chk("ovf", i, ovf_w[i], m_ovf[i]);
        chk("zero", i, zero_w[i], m_zero[i]);
      end
    end
  end
  task automatic go(input logic [7:0] ia, input logic [7:0] ib, input logic isub);
    @(negedge clk);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic watch;
    for (int i = 0; i < 3; i++) begin lat[i] = -1; nb[i] = 0; nd[i] = 0; end
    for (int l = 0; l < 40; l++) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_w[i]) nb[i]++;
        if (done_w[i]) begin nd[i]++; if (lat[i] < 0) lat[i] = l; end
      end
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      @(negedge clk);
    end
  endtask
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic isub);
    go(ia, ib, isub);
    watch();
    for (int i = 0; i < 3; i++) begin
      chk("latency", i, lat[i], nof(i));
      chk("busy_cycles", i, nb[i], nof(i));
    end
  endtask
  task automatic lit(input int i, input logic [7:0] es, input logic ec, input logic eo, input logic ez);
    chk("lit_s", i, s_w[i], es);
    chk("lit_cout", i, cout_w[i], ec);
    chk("lit_ovf", i, ovf_w[i], eo);
    chk("lit_zero", i, zero_w[i], ez);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) lit(i, 8'h00, 0, 0, 1);
    rst_n = 1'b1;
    run_op(8'h03, 8'h02, 0); lit(0, 8'h05, 0, 0, 0);
    run_op(8'hFE, 8'h02, 0); lit(0, 8'h00, 1, 0, 1);
    run_op(8'h7F, 8'h01, 0); lit(0, 8'h80, 0, 1, 0);
    run_op(8'h0C, 8'h05, 1); lit(0, 8'h07, 1, 0, 0);
    run_op(8'h03, 8'h05, 1); lit(0, 8'hFE, 0, 0, 0);
    run_op(8'h80, 8'h01, 1); lit(0, 8'h7F, 1, 1, 0);
    run_op(8'hFF, 8'h01, 0);
    for (int i = 0; i < 3; i++) lit(i, 8'h00, 1, 0, 1);
    go(8'h10, 8'h20, 0);
    a = 8'h55; b = 8'h66; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    watch();
    for (int i = 0; i < 3; i++) begin chk("done_count", i, nd[i], 1); lit(i, 8'h30, 0, 0, 0); end
    go(8'h01, 8'h02, 0);
    for (int l = 0; l < 10 && !done_w[0]; l++) @(negedge clk);
    chk("b2b_first_done", 0, done_w[0], 1);
    a = 8'h10; b = 8'h05; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    watch();
    chk("b2b_latency", 0, lat[0], 2);
    lit(0, 8'h0B, 1, 0, 0); lit(1, 8'h03, 0, 0, 0); lit(2, 8'h0B, 1, 0, 0);
    go(8'h44, 8'h11, 0);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      lit(i, 8'h00, 0, 0, 1);
      chk("rst_busy", i, busy_w[i], 0);
      chk("rst_done", i, done_w[i], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_op(8'h11, 8'h22, 0);
    for (int i = 0; i < 3; i++) lit(i, 8'h33, 0, 0, 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
